lfsr_stream_cipher: RTL
=======================

LFSR_STREAM_CIPHER -- requirements
Module: lfsr_stream_cipher

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, width of data words (1..64).
REQ-002 SHALL provide parameter LFSR_W, default 16, keystream LFSR width (8..64).
REQ-003 SHALL provide parameter TAPS, default 16'hB400, Galois feedback mask, LFSR_W bits.
REQ-004 SHALL provide parameter SEED, default 16'hACE1, reset and fallback LFSR state, nonzero.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port seed_load  input  1  load seed_in into LFSR this cycle.
REQ-008 SHALL have port seed_in  input  LFSR_W  new key/IV value.
REQ-009 SHALL have port mode  input  2  00 bypass, 01 encrypt, 10 decrypt, 11 bypass.
REQ-010 SHALL have port in_valid  input  1  in_data/mode valid.
REQ-011 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-012 SHALL have port in_data  input  DATA_W  plaintext or ciphertext word.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts word.
REQ-015 SHALL have port out_data  output  DATA_W  processed word.
REQ-016 SHALL have port out_mode  output  2  mode the output word was processed with.
REQ-017 SHALL have port word_cnt  output  32  count of cipher words (mode 01/10) accepted since last reset/seed load.

Function
REQ-018 Accept = in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (single output register, no bubble under continuous flow).
REQ-019 Latency SHALL be exactly 1 cycle: word accepted in cycle N appears on out_data with out_valid in cycle N+1.
REQ-020 LFSR step SHALL be Galois right-shift: out bit = state[0]; next = (state>>1) ^ (state[0] ? TAPS : 0).
REQ-021 Keystream word SHALL be DATA_W consecutive out bits from current state, bit 0 first, computed in one cycle.
REQ-022 Modes 01 and 10 SHALL output in_data XOR keystream word and advance LFSR by DATA_W steps on accept.
REQ-023 Modes 00 and 11 SHALL output in_data unchanged and SHALL NOT advance LFSR or word_cnt.
REQ-024 While out_valid && !out_ready, out_data, out_mode, out_valid SHALL hold stable; LFSR SHALL NOT advance.
REQ-025 seed_load SHALL set LFSR to seed_in, or to SEED if seed_in == 0 (lock-up protection), and clear word_cnt.
REQ-026 seed_load and accept in same cycle: accepted word SHALL use the old state; seed load wins for next LFSR state; word_cnt SHALL become 0.
REQ-027 seed_load SHALL NOT affect a word already held in the output register.
REQ-028 word_cnt SHALL wrap from 2^32-1 to 0 silently.
REQ-029 LFSR SHALL never reach all-zero state.

Reset
REQ-030 On reset: LFSR = SEED, out_valid = 0, out_data = 0, out_mode = 00, word_cnt = 0.
REQ-031 Reset SHALL override seed_load and accept in the same cycle; in_ready SHALL be 1 in the cycle after reset.
REQ-032 Reset mid-stream SHALL discard any held output word.

Structure
REQ-033 Package stream_cipher_pkg SHALL hold mode encodings (MODE_BYPASS, MODE_ENC, MODE_DEC, MODE_RSVD) and default TAPS/SEED constants.
REQ-034 Sub-module lfsr_keystream SHALL compute keystream word and next state combinationally from current state (parameters DATA_W, LFSR_W, TAPS).
REQ-035 Top level SHALL contain LFSR state register, output register, handshake and counter.

Verification
REQ-036 Round trip: reset, encrypt 100 random bytes, reset, decrypt the ciphertext with mode 10 -> output equals original bytes, word_cnt = 100.
REQ-037 Bypass: mode 00 in_data 8'hA5 -> out_data 8'hA5 next cycle; mode 11 8'h3C -> 8'h3C; word_cnt and LFSR unchanged.
REQ-038 Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, out_data stable, next accepted word uses unadvanced keystream.
REQ-039 Zero seed: seed_load with seed_in = 0 -> LFSR = 16'hACE1, word_cnt = 0; first encrypted byte equals that after reset.
REQ-040 Simultaneous seed_load + accept: word encrypted with old state; following word matches keystream from seed_in.
REQ-041 Reset mid-stream with out_valid = 1, out_ready = 0 -> out_valid = 0, out_data = 0, LFSR = SEED next cycle.

Source files
------------

// File: rtl/stream_cipher_pkg.sv
// Shared mode encodings and default keystream constants
// for the LFSR stream cipher.
package stream_cipher_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_ENC    = 2'b01,
    MODE_DEC    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  function automatic logic is_cipher(
    input logic [1:0] m
  );
    return (m == MODE_ENC) || (m == MODE_DEC);
  endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// Unrolled Galois LFSR: one DATA_W-bit keystream word
// and the post-word state, purely combinational.
module lfsr_keystream #(
  parameter int unsigned          DATA_W = 8,
  parameter int unsigned          LFSR_W = 16,
  parameter logic [LFSR_W-1:0]    TAPS   = 16'hB400
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [DATA_W-1:0] ks_o,
  output logic [LFSR_W-1:0] next_o
);

  always_comb begin
    logic [LFSR_W-1:0] s;
    s    = state_i;
    ks_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ks_o[i] = s[0];
      s = (s >> 1) ^ (s[0] ? TAPS : '0);
    end
    next_o = s;
  end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// XOR stream cipher with one-deep output register and
// valid/ready handshake on both sides.
module lfsr_stream_cipher
  import stream_cipher_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_mode,
  output logic [31:0]       word_cnt
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [DATA_W-1:0] ks;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        mode_q, mode_d;
  logic              valid_q, valid_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              accept;
  logic              cipher;

  lfsr_keystream #(
    .DATA_W (DATA_W),
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS)
  ) u_ks (
    .state_i (lfsr_q),
    .ks_o    (ks),
    .next_o  (lfsr_nxt)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cipher   = is_cipher(mode);

  always_comb begin
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      mode_d  = mode;
      data_d  = cipher ? (in_data ^ ks) : in_data;
      if (cipher) begin
        lfsr_d = lfsr_nxt;
        cnt_d  = cnt_q + 32'd1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // Seed load beats the advance; an all-zero seed would lock up.
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q  <= SEED;
      data_q  <= '0;
      mode_q  <= MODE_BYPASS;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_mode  = mode_q;
  assign word_cnt  = cnt_q;

endmodule
